team_08_tft_pixel_source: RTL and testbench



---
 rtl/team_08_tft_pkg.sv | 34 +++
 rtl/team_08_tft_cell_map.sv | 36 +++
 rtl/team_08_tft_pixel_source.sv | 127 ++++++++++++
 tb/tb_team_08_tft_pixel_source.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_08_tft_pkg.sv
`default_nettype none
// ============================================================================
// team_08_tft_pkg : shared types, palette and geometry for the TFT pixel source
// Rev 1.0
// ============================================================================
package team_08_tft_pkg;

   localparam int DEF_H_RES      = 240;
   localparam int DEF_V_RES      = 320;
   localparam int DEF_CELL_SHIFT = 4;
   localparam int CELL_COLS      = 15;
   localparam int CELL_ROWS      = 20;
   localparam int CELL_COUNT     = CELL_COLS * CELL_ROWS;

   localparam logic [2:0] TFT_LOOP_STATE = 3'd4;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t GRID_COLOR = 16'h4208;

   localparam rgb565_t PALETTE [16] = '{
      16'h0000, 16'hFFFF, 16'hF800, 16'h07E0,
      16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
      16'h8410, 16'h8000, 16'h0400, 16'h0010,
      16'hFD20, 16'h8010, 16'h0410, 16'hC618
   };

   // Row-major linear cell address, 0..299
   function automatic logic [8:0] cell_index(input logic [4:0] row, input logic [3:0] col);
      return ({4'd0, row} * 9'd15) + {5'd0, col};
   endfunction

endpackage
`default_nettype wire

// File: rtl/team_08_tft_cell_map.sv
`default_nettype none
// ============================================================================
// team_08_tft_cell_map : 300x4 cell colour store, one sync write, one registered read
// Rev 1.0
// ============================================================================
module team_08_tft_cell_map
   import team_08_tft_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       we,
   input  logic [8:0] waddr,
   input  logic [3:0] wdata,
   input  logic [8:0] raddr,
   output logic [3:0] rdata
);

   logic [3:0] mem [CELL_COUNT];

   // A read colliding with a write returns the pre-write contents
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < CELL_COUNT; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[waddr] <= wdata;
         end
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/team_08_tft_pixel_source.sv
`default_nettype none
// ============================================================================
// team_08_tft_pixel_source : raster walker feeding RGB565 pixels to the ILI9341 driver
// Optional grid overlay: define TEAM_08_TFT_GRID_EN. Rev 1.0
// ============================================================================
module team_08_tft_pixel_source
   import team_08_tft_pkg::*;
#(
   parameter int         H_RES      = DEF_H_RES,
   parameter int         V_RES      = DEF_V_RES,
   parameter int         CELL_SHIFT = DEF_CELL_SHIFT,
   parameter logic [2:0] LOOP_STATE = TFT_LOOP_STATE
)(
   input  logic        clk,
   input  logic        nrst,
   input  logic        framebufferClk,
   input  logic [2:0]  tftstate,
   input  logic        cell_we,
   input  logic [3:0]  cell_col,
   input  logic [4:0]  cell_row,
   input  logic [3:0]  cell_color,
   output logic [15:0] framebufferData,
   output logic [7:0]  pixel_x,
   output logic [8:0]  pixel_y,
   output logic        frame_done
);

   localparam logic [7:0] X_LAST = 8'(H_RES - 1);
   localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

   logic       req_q;
   logic       advance;
   logic [7:0] x;
   logic [8:0] y;
   logic [7:0] x_s1;
   logic [8:0] y_s1;
   logic [3:0] cell_rd;
   logic [8:0] rd_addr;
   logic [8:0] wr_addr;
   logic       wr_en;
   rgb565_t    pix_color;

   assign advance = framebufferClk & ~req_q & (tftstate == LOOP_STATE);
   assign rd_addr = cell_index(5'(y >> CELL_SHIFT), 4'(x >> CELL_SHIFT));
   assign wr_addr = cell_index(cell_row, cell_col);
   assign wr_en   = cell_we & (cell_col <= 4'(CELL_COLS - 1)) & (cell_row <= 5'(CELL_ROWS - 1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         req_q      <= 1'b0;
         x          <= '0;
         y          <= '0;
         frame_done <= 1'b0;
      end else begin
         req_q      <= framebufferClk;
         frame_done <= 1'b0;
         if (tftstate != LOOP_STATE) begin
            x <= '0;
            y <= '0;
         end else if (advance) begin
            if (x == X_LAST) begin
               x <= '0;
               if (y == Y_LAST) begin
                  y          <= '0;
                  frame_done <= 1'b1;
               end else begin
                  y <= y + 9'd1;
               end
            end else begin
               x <= x + 8'd1;
            end
         end
      end
   end

   // Stage 1: cell read (inside the map) plus coordinate delay
   team_08_tft_cell_map u_cell_map (
      .clk   (clk),
      .nrst  (nrst),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (cell_color),
      .raddr (rd_addr),
      .rdata (cell_rd)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         x_s1 <= '0;
         y_s1 <= '0;
      end else begin
         x_s1 <= x;
         y_s1 <= y;
      end
   end

`ifdef TEAM_08_TFT_GRID_EN
   logic grid_s1;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         grid_s1 <= 1'b0;
      end else begin
         grid_s1 <= (x[CELL_SHIFT-1:0] == '0) || (y[CELL_SHIFT-1:0] == '0);
      end
   end

   assign pix_color = grid_s1 ? GRID_COLOR : PALETTE[cell_rd];
`else
   assign pix_color = PALETTE[cell_rd];
`endif

   // Stage 2: palette lookup, coordinates kept aligned with the data
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         framebufferData <= '0;
         pixel_x         <= '0;
         pixel_y         <= '0;
      end else begin
         framebufferData <= pix_color;
         pixel_x         <= x_s1;
         pixel_y         <= y_s1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_team_08_tft_pixel_source.sv
`default_nettype none
// Bench for team_08_tft_pixel_source: directed table, sequences and a randomized
// run checked against a pixel-index reference model (two instances: full and short frame).
`timescale 1ns/1ps
module tb_team_08_tft_pixel_source;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        fb = 1'b0;
   logic [2:0]  tftstate = 3'd0;
   logic        cell_we = 1'b0;
   logic [3:0]  cell_col = 4'd0;
   logic [4:0]  cell_row = 5'd0;
   logic [3:0]  cell_color = 4'd0;
   logic [15:0] data0, data1;
   logic [7:0]  px0, px1;
   logic [8:0]  py0, py1;
   logic        fd0, fd1;

   always #5 clk = ~clk;

   team_08_tft_pixel_source dut0 (
      .clk(clk), .nrst(nrst), .framebufferClk(fb), .tftstate(tftstate),
      .cell_we(cell_we), .cell_col(cell_col), .cell_row(cell_row), .cell_color(cell_color),
      .framebufferData(data0), .pixel_x(px0), .pixel_y(py0), .frame_done(fd0)
   );

   team_08_tft_pixel_source #(.V_RES(4)) dut1 (
      .clk(clk), .nrst(nrst), .framebufferClk(fb), .tftstate(tftstate),
      .cell_we(cell_we), .cell_col(cell_col), .cell_row(cell_row), .cell_color(cell_color),
      .framebufferData(data1), .pixel_x(px1), .pixel_y(py1), .frame_done(fd1)
   );

   localparam logic [15:0] PAL [16] = '{
      16'h0000, 16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
      16'h8410, 16'h8000, 16'h0400, 16'h0010, 16'hFD20, 16'h8010, 16'h0410, 16'hC618
   };

   int checks = 0;
   int failures = 0;
   int fd_cnt0 = 0;
   int fd_cnt1 = 0;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] c;
   } pix_t;

   int   vres [2] = '{320, 4};
   int   pos [2];
   bit   fd_exp [2];
   int   cmem [20][15];
   bit   prev_fb;
   pix_t h1 [2];
   pix_t h2 [2];
   pix_t ex [2];

   function automatic pix_t pix(input int k);
      pix_t p;
      p.x = pos[k] % 240;
      p.y = pos[k] / 240;
      p.c = PAL[cmem[p.y / 16][p.x / 16]];
`ifdef TEAM_08_TFT_GRID_EN
      if ((p.x % 16 == 0) || (p.y % 16 == 0)) p.c = 16'h4208;
`endif
      return p;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 15; c++) cmem[r][c] = 0;
      prev_fb = 0;
      for (int k = 0; k < 2; k++) begin
         pos[k] = 0;
         fd_exp[k] = 0;
         h1[k] = pix(k);
         h2[k] = pix(k);
         ex[k] = pix(k);
      end
   endtask

   // Reference: output after an edge shows the pixel/cell state from two edges earlier
   task automatic model_edge();
      bit adv;
      if (!nrst) begin
         model_reset();
         return;
      end
      adv = fb && !prev_fb && (tftstate == 3'd4);
      for (int k = 0; k < 2; k++) begin
         fd_exp[k] = 0;
         if (tftstate != 3'd4) pos[k] = 0;
         else if (adv) begin
            pos[k]++;
            if (pos[k] == 240 * vres[k]) begin
               pos[k] = 0;
               fd_exp[k] = 1;
            end
         end
      end
      if (cell_we && int'(cell_col) < 15 && int'(cell_row) < 20)
         cmem[cell_row][cell_col] = int'(cell_color);
      prev_fb = fb;
      for (int k = 0; k < 2; k++) begin
         ex[k] = h2[k];
         h2[k] = h1[k];
         h1[k] = pix(k);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare_model();
      check("dut0_x",    32'(px0),   32'(ex[0].x));
      check("dut0_y",    32'(py0),   32'(ex[0].y));
      check("dut0_data", 32'(data0), 32'(ex[0].c));
      check("dut0_fd",   32'(fd0),   32'(fd_exp[0]));
      check("dut1_x",    32'(px1),   32'(ex[1].x));
      check("dut1_y",    32'(py1),   32'(ex[1].y));
      check("dut1_data", 32'(data1), 32'(ex[1].c));
      check("dut1_fd",   32'(fd1),   32'(fd_exp[1]));
   endtask

   task automatic cycle(input bit f, input int st, input bit we, input int col, input int row, input int colr);
      fb = f;
      tftstate = 3'(st);
      cell_we = we;
      cell_col = 4'(col);
      cell_row = 5'(row);
      cell_color = 4'(colr);
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
      fd_cnt0 += int'(fd0);
      fd_cnt1 += int'(fd1);
   endtask

   task automatic edges(input int n, input bit rnd_writes);
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, 4, 1'b0, 0, 0, 0);
         if (rnd_writes && $urandom_range(0, 3) == 0)
            cycle(1'b0, 4, 1'b1, $urandom_range(0, 15), $urandom_range(0, 21), $urandom_range(0, 15));
         else
            cycle(1'b0, 4, 1'b0, 0, 0, 0);
      end
   endtask

   typedef struct {
      bit          f;
      int          st;
      bit          we;
      int          col;
      int          row;
      int          colr;
      int          ex;
      int          ey;
      logic [15:0] ec;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #5ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1, 4, 1, 0,  0, 3, 0, 0, 16'h0000};
      tbl[1]  = '{1, 4, 0, 0,  0, 0, 0, 0, 16'h0000};
      tbl[2]  = '{0, 4, 0, 0,  0, 0, 1, 0, 16'h07E0};
      tbl[3]  = '{1, 4, 0, 0,  0, 0, 1, 0, 16'h07E0};
      tbl[4]  = '{1, 4, 1, 0,  0, 5, 1, 0, 16'h07E0};
      tbl[5]  = '{0, 4, 0, 0,  0, 0, 2, 0, 16'h07E0};
      tbl[6]  = '{0, 4, 0, 0,  0, 0, 2, 0, 16'hFFE0};
      tbl[7]  = '{1, 2, 0, 0,  0, 0, 2, 0, 16'hFFE0};
      tbl[8]  = '{0, 2, 0, 0,  0, 0, 2, 0, 16'hFFE0};
      tbl[9]  = '{1, 2, 0, 0,  0, 0, 0, 0, 16'hFFE0};
      tbl[10] = '{1, 4, 0, 0,  0, 0, 0, 0, 16'hFFE0};
      tbl[11] = '{1, 4, 1, 15, 0, 7, 0, 0, 16'hFFE0};
      tbl[12] = '{0, 4, 1, 0, 20, 7, 0, 0, 16'hFFE0};
      tbl[13] = '{0, 4, 1, 0,  0, 0, 0, 0, 16'hFFE0};
      tbl[14] = '{0, 4, 0, 0,  0, 0, 0, 0, 16'hFFE0};
      tbl[15] = '{0, 4, 0, 0,  0, 0, 0, 0, 16'h0000};

      // Reset
      model_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 0, 0, 0);
      check("reset_data", 32'(data0), 32'h0);
      check("reset_x",    32'(px0),   32'h0);
      check("reset_y",    32'(py0),   32'h0);
      check("reset_fd",   32'(fd0),   32'h0);

      // Directed table: first advance, same-cycle write/read, non-loop state, held level, range
      nrst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].f, tbl[i].st, tbl[i].we, tbl[i].col, tbl[i].row, tbl[i].colr);
         check($sformatf("tbl%0d_x", i),    32'(px0),   32'(tbl[i].ex));
         check($sformatf("tbl%0d_y", i),    32'(py0),   32'(tbl[i].ey));
         check($sformatf("tbl%0d_data", i), 32'(data0), 32'(tbl[i].ec));
         check($sformatf("tbl%0d_fd", i),   32'(fd0),   32'h0);
      end

      // Row 0 scan: cell (1,0) untouched by the col=15 write, then written with index 3
      edges(16, 1'b0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("scan_x16",      32'(px0),   32'd16);
      check("scan_x16_data", 32'(data0), 32'h0000);
      cycle(1'b0, 4, 1'b1, 1, 0, 3);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("scan_x16_pal3", 32'(data0), 32'h07E0);
      edges(224, 1'b0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("line_wrap_x", 32'(px0), 32'd0);
      check("line_wrap_y", 32'(py0), 32'd1);

      // Short-frame instance completes its 960-pixel frame
      fd_cnt0 = 0;
      fd_cnt1 = 0;
      edges(720, 1'b0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("frame_pulses_short", 32'(fd_cnt1), 32'd1);
      check("frame_pulses_full",  32'(fd_cnt0), 32'd0);
      check("frame_wrap_x", 32'(px1), 32'd0);
      check("frame_wrap_y", 32'(py1), 32'd0);
      check("full_y4",      32'(py0), 32'd4);

      // Non-loop state: toggling request does nothing
      fd_cnt0 = 0;
      fd_cnt1 = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 2, 1'b0, 0, 0, 0);
         cycle(1'b0, 2, 1'b0, 0, 0, 0);
      end
      check("idle_x",  32'(px0), 32'd0);
      check("idle_y",  32'(py0), 32'd0);
      check("idle_fd", 32'(fd_cnt0 + fd_cnt1), 32'd0);

      // Walk to (100,50) with random cell writes, then async reset mid-frame
      edges(50 * 240 + 100, 1'b1);
      cycle(1'b0, 4, 1'b1, 6, 3, 9);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("walk_x",    32'(px0),   32'd100);
      check("walk_y",    32'(py0),   32'd50);
      check("walk_data", 32'(data0), 32'h8000);
      #2 nrst = 1'b0;
      #1;
      check("async_rst_data", 32'(data0), 32'h0);
      check("async_rst_x",    32'(px0),   32'h0);
      check("async_rst_y",    32'(py0),   32'h0);
      model_reset();
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      cycle(1'b1, 4, 1'b0, 0, 0, 0);
      nrst = 1'b1;
      edges(3, 1'b0);
      cycle(1'b0, 4, 1'b0, 0, 0, 0);
      check("restart_x", 32'(px0), 32'd3);
      check("restart_y", 32'(py0), 32'd0);

      // Randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 9) < 7) ? ~fb : fb,
               ($urandom_range(0, 15) == 0) ? 2 : 4,
               ($urandom_range(0, 3) == 0),
               $urandom_range(0, 15), $urandom_range(0, 21), $urandom_range(0, 15));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
